// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch queue: the bubble opcode and
// the buffered entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched instructions. It has a synchronous clear, and its
// pointers and count use an asynchronous active-low reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !clear;
    do_pop   = pop && !clear && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count alone says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: it issues sequential fetches under a credit limit,
// buffers the responses in order, and presents the head to Fetch. A redirect
// flushes the buffered entries and drops the stale responses.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        InstrValidF,
  input  logic        StallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic [31:0]   redirect_base;
  logic          accept, keep, pop;
  fetch_entry_t  head, push_entry;

  always_comb begin
    redirect_base = {redirect_pc[31:2], 2'b00};
    credits_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    // Gating on reset keeps the port quiet while reset is held.
    mem_req_valid = reset && !redirect && (credits_used < CREDITS);
    mem_req_addr  = req_pc_q;
    accept        = mem_req_valid && mem_req_ready;
    keep          = mem_rsp_valid && !redirect && (discard_q == '0);

    InstrValidF = (fifo_count != '0);
    pop         = InstrValidF && !StallF && !redirect;
    InstrF      = InstrValidF ? head.instr : NOP_INSTR;
    PCF         = InstrValidF ? head.pc : rsp_pc_q;

    push_entry.instr = mem_rsp_data;
    push_entry.pc    = rsp_pc_q;

    req_pc_d      = req_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(mem_rsp_valid);
    if (redirect) begin
      req_pc_d  = redirect_base;
      rsp_pc_d  = redirect_base;
      discard_d = outstanding_q - CW'(mem_rsp_valid);
    end else begin
      if (accept) req_pc_d = req_pc_q + 32'd4;
      if (keep)   rsp_pc_d = rsp_pc_q + 32'd4;
      if (mem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc_q      <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      req_pc_q      <= req_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue. It contains a variable-latency
// memory model, and it tracks expected instructions for each redirect epoch.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'hE1A0_0000;
  localparam logic [31:0] KEY    = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [31:0] InstrF, PCF;
  logic        InstrValidF;
  logic        StallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          cyc = 0, lat = 1, epoch = 0, buffered = 0, pops = 0;
  int          n_pass = 0, n_total = 0;
  logic [31:0] next_req = RST_PC;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .InstrF(InstrF), .PCF(PCF), .InstrValidF(InstrValidF),
    .StallF(StallF), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  // One clock cycle: memory drives its response, outputs are scored, then the model advances.
  task automatic step();
    logic acc, rspv, keep, popd, want_vld;
    logic [31:0] want_pc, want_instr;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_at(mem_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
    n_total++;
    if (InstrValidF !== (buffered != 0))
      $display("FAIL sb_valid cyc %0d: got %0b want %0b", cyc, InstrValidF, buffered != 0);
    else n_pass++;
    if (buffered != 0 && exp_q.size() > 0) begin
      want_pc = exp_q[0].pc; want_instr = exp_q[0].instr;
    end else begin
      want_pc = (exp_q.size() > 0) ? exp_q[0].pc : next_req; want_instr = NOP;
    end
    n_total++;
    if (InstrF !== want_instr || PCF !== want_pc)
      $display("FAIL sb_head cyc %0d: got %h@%h want %h@%h", cyc, InstrF, PCF, want_instr, want_pc);
    else n_pass++;
    want_vld = !redirect && ((mem_q.size() + buffered) < DEPTH);
    n_total++;
    if (mem_req_valid !== want_vld)
      $display("FAIL sb_req_valid cyc %0d: got %0b want %0b", cyc, mem_req_valid, want_vld);
    else n_pass++;
    if (mem_req_valid === 1'b1) begin
      n_total++;
      if (mem_req_addr !== next_req)
        $display("FAIL sb_req_addr cyc %0d: got %h want %h", cyc, mem_req_addr, next_req);
      else n_pass++;
    end
    acc  = (mem_req_valid === 1'b1) && mem_req_ready;
    rspv = mem_rsp_valid;
    keep = rspv && (mem_q[0].epoch == epoch) && !redirect;
    popd = (InstrValidF === 1'b1) && !StallF && !redirect;
    @(posedge clk);
    cyc++;
    if (rspv) void'(mem_q.pop_front());
    if (keep) buffered++;
    if (popd) begin
      if (buffered > 0) buffered--;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pops++;
    end
    if (acc) begin
      mem_q.push_back('{addr: mem_req_addr, due: cyc + lat - 1, epoch: epoch});
      exp_q.push_back('{pc: mem_req_addr, instr: word_at(mem_req_addr)});
      next_req = next_req + 32'd4;
    end
    if (redirect) begin
      epoch++;
      exp_q.delete();
      buffered = 0;
      next_req = {redirect_pc[31:2], 2'b00};
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== RST_PC)
      $display("FAIL reset_req: got %0b/%h want 0/%h", mem_req_valid, mem_req_addr, RST_PC);
    else n_pass++;
    n_total++;
    if (InstrF !== NOP || PCF !== RST_PC || InstrValidF !== 1'b0)
      $display("FAIL reset_out: got %h/%h/%0b want %h/%h/0", InstrF, PCF, InstrValidF, NOP, RST_PC);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    int lows;
    lat = 1; mem_req_ready = 1'b1; StallF = 1'b0;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC)
      $display("FAIL first_req: got %0b/%h want 1/%h", mem_req_valid, mem_req_addr, RST_PC);
    else n_pass++;
    for (int i = 0; i < 4; i++) step();
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (InstrValidF !== 1'b1) lows++;
      step();
    end
    n_total++;
    if (lows != 0) $display("FAIL stream_bubbles: got %0d want 0", lows);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] hold_i, hold_pc, prev_pc;
    StallF = 1'b1;
    hold_i = InstrF; hold_pc = PCF;
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (InstrF !== hold_i || PCF !== hold_pc)
        $display("FAIL stall_frozen: got %h@%h want %h@%h", InstrF, PCF, hold_i, hold_pc);
      else n_pass++;
    end
    n_total++;
    if (mem_req_valid !== 1'b0 || InstrValidF !== 1'b1)
      $display("FAIL stall_credits: got req %0b vld %0b want 0/1", mem_req_valid, InstrValidF);
    else n_pass++;
    StallF = 1'b0;
    prev_pc = PCF - 32'd4;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (InstrValidF !== 1'b1 || PCF !== prev_pc + 32'd4)
        $display("FAIL stall_release: got %0b@%h want 1@%h", InstrValidF, PCF, prev_pc + 32'd4);
      else n_pass++;
      prev_pc = PCF;
      step();
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 3; mem_req_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    mem_req_ready = 1'b1;
    step(); step();
    mem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0; mem_req_ready = 1'b1;
    n_total++;
    if (mem_req_addr !== 32'h100) $display("FAIL redir_addr: got %h want 00000100", mem_req_addr);
    else n_pass++;
    for (int i = 0; i < 30 && InstrValidF !== 1'b1; i++) step();
    n_total++;
    if (InstrValidF !== 1'b1 || PCF !== 32'h100 || InstrF !== word_at(32'h100))
      $display("FAIL redir_first: got %0b %h@%h want 1 %h@00000100", InstrValidF, InstrF, PCF, word_at(32'h100));
    else n_pass++;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_redirect_collide();
    lat = 1; mem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 10; i++) begin
      if (InstrValidF === 1'b1 && mem_q.size() > 0 && mem_q[0].due <= cyc) break;
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    n_total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL collide_flush: got %0b/%h want 0/%h", InstrValidF, InstrF, NOP);
    else n_pass++;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_back_to_back();
    lat = 4; mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 40 && InstrValidF !== 1'b1; i++) step();
    n_total++;
    if (InstrValidF !== 1'b1 || PCF !== 32'h300)
      $display("FAIL b2b_first: got %0b@%h want 1@00000300", InstrValidF, PCF);
    else n_pass++;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid();
    int pops0;
    lat = 2;
    for (int i = 0; i < 6; i++) step();
    #2;
    reset = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== RST_PC)
      $display("FAIL midrst_req: got %0b/%h want 0/%h", mem_req_valid, mem_req_addr, RST_PC);
    else n_pass++;
    n_total++;
    if (InstrF !== NOP || PCF !== RST_PC || InstrValidF !== 1'b0)
      $display("FAIL midrst_out: got %h/%h/%0b want %h/%h/0", InstrF, PCF, InstrValidF, NOP, RST_PC);
    else n_pass++;
    mem_q.delete(); exp_q.delete();
    buffered = 0; next_req = RST_PC; epoch++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC)
      $display("FAIL midrst_restart: got %0b/%h want 1/%h", mem_req_valid, mem_req_addr, RST_PC);
    else n_pass++;
    pops0 = pops;
    for (int i = 0; i < 15; i++) step();
    n_total++;
    if (pops - pops0 < 8) $display("FAIL midrst_flow: got %0d pops want >= 8", pops - pops0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch queue between instruction memory and the pipelined datapath's Fetch stage. Issues sequential fetch requests over a valid/ready memory port with variable response latency, buffers returned instructions in order, and presents one instruction per cycle to the Fetch/Decode register. It absorbs `StallF`, and on a branch redirect it flushes buffered and in-flight instructions. When empty it supplies a NOP so the datapath sees a bubble.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; also the maximum outstanding plus buffered instructions (power of 2, ≥2).
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_req_addr`  out  32  word-aligned fetch address.
- `mem_rsp_valid`  in  1  response valid. Responses return in request order, at least 1 cycle after acceptance.
- `mem_rsp_data`  in  32  instruction word.
- `InstrF`  out  32  head instruction, or NOP (32'hE1A0_0000) when empty.
- `PCF`  out  32  address of the head instruction.
- `InstrValidF`  out  1  head entry is real (not a NOP bubble).
- `StallF`  in  1  datapath holds Fetch; do not pop.
- `redirect`  in  1  branch or PC write taken.
- `redirect_pc`  in  32  new fetch address (bits [1:0] ignored, forced 0).

## Operation
- State registers:
  - `req_pc`: next address to request.
  - `rsp_pc`: address of the next kept response.
  - `outstanding`: accepted requests without a response, width clog2(DEPTH+1).
  - `discard`: stale responses still to drop.
  - FIFO `count`, `rd_ptr`, `wr_ptr`.
- Issue rule: `mem_req_valid = !redirect && (outstanding + count) < DEPTH`. On accept (`valid && ready`), `req_pc += 4` (wraps at 2^32) and `outstanding++`.
- Response handling: on `mem_rsp_valid`, `outstanding--`.
  - If `discard != 0`, then `discard--` and the data is dropped.
  - Otherwise push {`mem_rsp_data`, `rsp_pc`} and set `rsp_pc += 4`.
- Pop: when `InstrValidF && !StallF`, pop the head.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- Redirect has priority over everything. In that cycle:
  - the FIFO is cleared (`count = 0`, pointers reset);
  - `req_pc` and `rsp_pc` are set to `redirect_pc`;
  - `discard = outstanding - (rsp_valid this cycle)`;
  - no request is issued and any response this cycle is dropped.
- The credit check guarantees a push never finds the FIFO full. Overflow is an assertion failure, not a handled case.
- Output rules:
  - When `count == 0`: `InstrF` = NOP, `InstrValidF = 0`, and `PCF = rsp_pc`.
  - When `count != 0`: `InstrF` and `PCF` come from the head entry.

## Timing
- Reset (async assert): `req_pc = rsp_pc = RESET_PC`, all counters 0.
  - Outputs during reset: `mem_req_valid = 0`, `mem_req_addr = RESET_PC`, `InstrF` = NOP, `PCF = RESET_PC`, `InstrValidF = 0`.
- First request: `mem_req_valid` rises combinationally in the first cycle after reset deasserts.
- Latency: a response sampled at edge N is visible on `InstrF` (with `InstrValidF = 1`) after edge N. There is no combinational bypass from `mem_rsp_data` to `InstrF`.
- Redirect sampled at edge N:
  - `mem_req_addr = redirect_pc` from cycle N+1;
  - outputs show a bubble from N+1 until the first kept response is pushed.
- A back-to-back redirect recomputes `discard` from the live `outstanding`, so all earlier streams are dropped.
- `StallF` held high: `InstrF` and `PCF` are stable; requests continue until credits run out.
- Reset asserted mid-operation: the state is abandoned immediately. Responses to requests issued before reset are the memory's responsibility; the memory also resets.

## Structure
- Package `fetch_pkg`: `NOP_INSTR` constant (32'hE1A0_0000) and the `fetch_entry_t` struct {`instr` [31:0], `pc` [31:0]}.
- One sub-module, `fetch_fifo`: a synchronous FIFO of `fetch_entry_t` with `push`, `pop`, `clear`, `count`, and an async active-low reset.
- Counters, credit logic and redirect logic live in the top module.

## Test plan
- Reset, memory with 1-cycle latency, `StallF = 0`: requests go to 0x0, 0x4, 0x8…; the `PCF`/`InstrF` stream is in order with one instruction per cycle after fill, and `InstrValidF` stays high.
- `StallF` high for 10 cycles with ready memory: at most 4 requests are outstanding plus buffered, `mem_req_valid` drops, and `InstrF`/`PCF` are frozen. After release the 4 entries pop on consecutive cycles.
- Memory latency 3 cycles, redirect to 0x100 with 2 requests in flight: both stale responses are dropped, the next `mem_req_addr` is 0x100, and the first valid `PCF` is 0x100.
- Redirect in the same cycle as a response and a pop: the response is dropped, the FIFO is empty next cycle, and `InstrF` = 0xE1A00000.
- Redirect at 0x200, then 0x300 two cycles later (latency 4): no instruction from 0x0 or 0x200 streams appears; the first valid `PCF` is 0x300.
- Reset asserted mid-stream: all outputs immediately return to their reset values, and fetching restarts at `RESET_PC`.
